// File: rtl/hdmi_timing_pkg.sv
// Shared types and default 640x480@60 timing for the HDMI video timing path.
package hdmi_timing_pkg;

    localparam int unsigned CNT_W = 12;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/video_counter.sv
// Horizontal/vertical raster position counter pair with wrap, advance and clear.
module video_counter
    import hdmi_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_TOTAL = 525
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Step h every advance cycle; step v when h wraps; clear parks at (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (clear) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (advance) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/hdmi_video_timing.sv
// Video timing sequencer: raster FSM, upstream pixel handshake and the
// registered sync/active/RGB stage that feeds the HDMI encoder.
module hdmi_video_timing
    import hdmi_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start,
    output logic        busy,
    output logic        underflow,
    input  logic        clr_underflow
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_LO = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    state_t           state, state_next;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             frame_end;
    logic             running;
    logic             de_req;
    logic             sync_h, sync_v;

    video_counter #(
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL)
    ) u_counter (
        .clk      (clk_pixel),
        .rst      (reset),
        .clear    (!running),
        .advance  (running),
        .h_cnt    (h_cnt),
        .v_cnt    (v_cnt),
        .frame_end(frame_end)
    );

    // FSM state register.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: a drop of enable lets the frame finish; re-enable while draining resumes without restart.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (!enable) state_next = DRAIN;
            DRAIN: begin
                if (enable)         state_next = RUN;
                else if (frame_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign running   = (state != IDLE);
    assign busy      = running;
    assign de_req    = running && (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign sync_h    = running && (h_cnt >= HS_LO) && (h_cnt < HS_HI);
    assign sync_v    = running && (v_cnt >= VS_LO) && (v_cnt < VS_HI);
    assign pix_ready = de_req;
    assign pix_x     = h_cnt;
    assign pix_y     = v_cnt;

    // Output register stage: one cycle behind the request, black on underflow.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            active      <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else begin
            active      <= de_req;
            hsync       <= sync_h ? HS_POL : ~HS_POL;
            vsync       <= sync_v ? VS_POL : ~VS_POL;
            frame_start <= running && (h_cnt == '0) && (v_cnt == '0);
            if (de_req && pix_valid) begin
                {red, green, blue} <= pix_data;
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

    // Sticky underflow flag; a new underflow outranks a clear in the same cycle.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset)                   underflow <= 1'b0;
        else if (de_req && !pix_valid) underflow <= 1'b1;
        else if (clr_underflow)      underflow <= 1'b0;
    end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing on a small 8x6 raster (4/1/2/1 by 3/1/1/1).
module tb_hdmi_video_timing;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        pix_valid = 1'b1;
    logic [23:0] pix_data = '0;
    logic        clr_underflow = 1'b0;
    logic        pix_ready, hsync, vsync, active, frame_start, busy, underflow;
    logic [11:0] pix_x, pix_y;
    logic [7:0]  red, green, blue;
    logic [7:0]  k = '0;

    int checks = 0;
    int errors = 0;

    hdmi_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk_pixel(clk), .reset(rst), .enable(enable),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
        .active(active), .red(red), .green(green), .blue(blue),
        .frame_start(frame_start), .busy(busy), .underflow(underflow),
        .clr_underflow(clr_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 running, 2 draining; m_p is the linear pixel index in the frame.
    int          m_mode = 0;
    int          m_p = 0;
    int          mh, mv;
    bit          m_on, m_req;
    logic        e_active = 1'b0, e_hs = 1'b1, e_vs = 1'b1, e_fs = 1'b0, e_uf = 1'b0;
    logic [23:0] e_rgb = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_p = 0;
            e_active = 1'b0; e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_uf = 1'b0;
        end else begin
            mh = m_p % HT;
            mv = m_p / HT;
            m_on = (m_mode != 0);
            m_req = m_on && mh < HA && mv < VA;
            e_active = m_req;
            e_rgb = (m_req && pix_valid) ? pix_data : 24'h0;
            e_hs = !(m_on && mh >= HA + HF && mh < HA + HF + HS);
            e_vs = !(m_on && mv >= VA + VF && mv < VA + VF + VS);
            e_fs = m_on && m_p == 0;
            if (m_req && !pix_valid) e_uf = 1'b1;
            else if (clr_underflow)  e_uf = 1'b0;
            if (m_mode == 0) begin
                if (enable) m_mode = 1;
            end else begin
                if (m_mode == 1) begin
                    if (!enable) m_mode = 2;
                end else if (enable) begin
                    m_mode = 1;
                end else if (m_p == FR - 1) begin
                    m_mode = 0;
                end
                m_p = (m_p + 1) % FR;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("active", active, e_active);
        chk("hsync", hsync, e_hs);
        chk("vsync", vsync, e_vs);
        chk("rgb", {red, green, blue}, e_rgb);
        chk("frame_start", frame_start, e_fs);
        chk("underflow", underflow, e_uf);
        chk("busy", busy, m_mode != 0);
        chk("pix_ready", pix_ready,
            (m_mode != 0) && (m_p % HT) < HA && (m_p / HT) < VA);
        chk("pix_x", pix_x, m_p % HT);
        chk("pix_y", pix_y, m_p / HT);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            k = k + 8'd1;
            pix_data = {k, ~k, k ^ 8'h5A};
        end
    endtask

    task automatic wait_pos(input int p);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_mode == 1 && m_p == p) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        chk("wait_pos_timeout", ok, 1'b1);
    endtask

    initial begin
        int n, n_rdy, n_fs, n_hs, n_vs, fs_last, fs_gap;

        // Reset with enable low, then hold idle for 100 cycles.
        step(3);
        chk("rst_hsync", hsync, 1'b1);
        chk("rst_vsync", vsync, 1'b1);
        chk("rst_active", active, 1'b0);
        chk("rst_rgb", {red, green, blue}, 24'h0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        step(100);
        chk("idle_busy", busy, 1'b0);
        chk("idle_hsync", hsync, 1'b1);
        chk("idle_active", active, 1'b0);

        // Free run: counts over two whole frames.
        enable = 1'b1;
        step(2);
        n_rdy = 0; n_fs = 0; n_hs = 0; n_vs = 0; fs_last = -1; fs_gap = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            step(1);
            if (pix_ready) n_rdy++;
            if (!hsync) n_hs++;
            if (!vsync) n_vs++;
            if (frame_start) begin
                n_fs++;
                if (fs_last >= 0) fs_gap = i - fs_last;
                fs_last = i;
            end
        end
        chk("ready_count", n_rdy, 24);
        chk("hsync_low_count", n_hs, 24);
        chk("vsync_low_count", n_vs, 16);
        chk("fs_count", n_fs, 2);
        chk("fs_period", fs_gap, 48);

        // Underflow at (2,1), then clear colliding with a new underflow.
        wait_pos(HT + 2);
        pix_valid = 1'b0;
        step(1);
        pix_valid = 1'b1;
        chk("uf_rgb", {red, green, blue}, 24'h0);
        chk("uf_active", active, 1'b1);
        chk("uf_set", underflow, 1'b1);
        step(10);
        chk("uf_sticky", underflow, 1'b1);
        wait_pos(HT + 2);
        pix_valid = 1'b0;
        clr_underflow = 1'b1;
        step(1);
        pix_valid = 1'b1;
        clr_underflow = 1'b0;
        chk("uf_set_wins", underflow, 1'b1);
        clr_underflow = 1'b1;
        step(1);
        clr_underflow = 1'b0;
        chk("uf_cleared", underflow, 1'b0);

        // Drop enable at (2,1): frame completes, busy falls after the last pixel.
        wait_pos(HT + 2);
        enable = 1'b0;
        n = 0;
        do begin
            step(1);
            n++;
        end while (busy && n < 200);
        chk("drain_len", n, 38);
        step(3);
        chk("post_drain_active", active, 1'b0);
        chk("post_drain_hsync", hsync, 1'b1);

        // Re-raise enable during drain: no restart, next frame at its normal boundary.
        enable = 1'b1;
        wait_pos(HT + 2);
        enable = 1'b0;
        step(5);
        enable = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!frame_start && n < 200);
        chk("resume_fs_delay", n, 34);

        // Asynchronous reset mid-line while active.
        n = 0;
        while (!active && n < 200) begin
            step(1);
            n++;
        end
        chk("found_active", active, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_active", active, 1'b0);
        chk("async_hsync", hsync, 1'b1);
        chk("async_vsync", vsync, 1'b1);
        chk("async_rgb", {red, green, blue}, 24'h0);
        step(2);
        rst = 1'b0;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!pix_ready && n < 200);
        chk("restart_latency", n, 1);
        chk("restart_x", pix_x, 12'd0);
        chk("restart_y", pix_y, 12'd0);
        step(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
